// File: rtl/call_driver.sv
// ---------------------------------------------------------------------------
// call_driver
//   Caller-side sequencer for a synthesized single-call kernel. It takes an
//   argument triple on a valid/ready request port and loads it into the
//   kernel. It then waits for the kernel's done level and returns the result
//   and a WAIT-cycle count on a valid/ready response port.
//
//   Optional feature macro: CALL_TIMEOUT_EN
//     When it is defined, a call that stays in WAIT for TIMEOUT_CYCLES cycles
//     without completing is aborted. The driver then returns resp_data=0,
//     resp_cycles=TIMEOUT_CYCLES and resp_timeout=1.
//     When it is undefined, WAIT lasts until the kernel completes and
//     resp_timeout stays 0.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/ready     request handshake; req_n/a/b carry the arguments
//   k_r_enable          kernel load/park (low only while waiting)
//   k_control_arr       kernel controlArr, tied to 0
//   k_init_n/a/b        kernel arguments, driven from the argument registers
//   k_w_enable          kernel done level, sampled only in WAIT
//   k_result            kernel result
//   resp_valid/ready    response handshake
//   resp_data           captured result
//   resp_cycles         number of WAIT cycles, saturating at all-ones
//   resp_timeout        call aborted by timeout
// ---------------------------------------------------------------------------
module call_driver #(
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_n,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic              k_r_enable,
   output logic              k_control_arr,
   output logic [DATA_W-1:0] k_init_n,
   output logic [DATA_W-1:0] k_init_a,
   output logic [DATA_W-1:0] k_init_b,
   input  logic              k_w_enable,
   input  logic [DATA_W-1:0] k_result,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [CNT_W-1:0]  resp_cycles,
   output logic              resp_timeout
);

`ifdef CALL_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_t;

   state_t            r_state;
   logic              r_req_ready;
   logic              r_k_r_enable;
   logic [DATA_W-1:0] r_arg_n;
   logic [DATA_W-1:0] r_arg_a;
   logic [DATA_W-1:0] r_arg_b;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_data;
   logic [CNT_W-1:0]  r_resp_cycles;
   logic              r_resp_timeout;

   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_timeout_hit;

   // The count includes the current WAIT cycle. It saturates at all-ones.
   assign w_cnt_inc     = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
   assign w_timeout_hit = TIMEOUT_EN && (w_cnt_inc == TIMEOUT_VAL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= StIdle;
         r_req_ready    <= 1'b0;
         r_k_r_enable   <= 1'b1;
         r_arg_n        <= '0;
         r_arg_a        <= '0;
         r_arg_b        <= '0;
         r_cnt          <= '0;
         r_resp_valid   <= 1'b0;
         r_resp_data    <= '0;
         r_resp_cycles  <= '0;
         r_resp_timeout <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_req_ready <= 1'b1;
               if (req_valid && r_req_ready) begin
                  r_arg_n     <= req_n;
                  r_arg_a     <= req_a;
                  r_arg_b     <= req_b;
                  r_req_ready <= 1'b0;
                  r_state     <= StLoad;
               end
            end
            // The kernel samples the new arguments on this edge because r_enable is still high.
            StLoad: begin
               r_cnt        <= '0;
               r_k_r_enable <= 1'b0;
               r_state      <= StWait;
            end
            StWait: begin
               if (k_w_enable) begin
                  // A completion in the same cycle as the timeout limit takes priority.
                  r_resp_data    <= k_result;
                  r_resp_cycles  <= w_cnt_inc;
                  r_resp_timeout <= 1'b0;
                  r_resp_valid   <= 1'b1;
                  r_k_r_enable   <= 1'b1;
                  r_state        <= StResp;
               end else if (w_timeout_hit) begin
                  r_resp_data    <= '0;
                  r_resp_cycles  <= TIMEOUT_VAL;
                  r_resp_timeout <= 1'b1;
                  r_resp_valid   <= 1'b1;
                  r_k_r_enable   <= 1'b1;
                  r_state        <= StResp;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            StResp: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= StIdle;
               end
            end
            default: begin
               r_state      <= StIdle;
               r_k_r_enable <= 1'b1;
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready     = r_req_ready;
   assign k_r_enable    = r_k_r_enable;
   assign k_control_arr = 1'b0;
   assign k_init_n      = r_arg_n;
   assign k_init_a      = r_arg_a;
   assign k_init_b      = r_arg_b;
   assign resp_valid    = r_resp_valid;
   assign resp_data     = r_resp_data;
   assign resp_cycles   = r_resp_cycles;
   assign resp_timeout  = r_resp_timeout;

endmodule

// File: doc/call_driver.md
Name: call_driver

Overview:
- Caller-side sequencer for synthesized single-call kernels, which present the interface r_enable, controlArr, init_n/init_a/init_b, w_enable and result.
- Accepts argument triples on a valid/ready request port and loads them into the kernel.
- Waits for the kernel's completion flag and returns the result plus a latency count on a valid/ready response port.
- Sits between the host or test fabric and one kernel instance.

Parameters:
DATA_W, 64, width of each argument and of the result
CNT_W, 16, width of the latency counter
TIMEOUT_CYCLES, 1024, WAIT-state cycle limit (used only when CALL_TIMEOUT_EN is defined)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request argument triple valid
req_ready  output  1  driver can accept a request
req_n  input  DATA_W  argument n
req_a  input  DATA_W  argument a
req_b  input  DATA_W  argument b
k_r_enable  output  1  to kernel r_enable (load/park)
k_control_arr  output  1  to kernel controlArr, constant 0
k_init_n  output  DATA_W  to kernel init_n
k_init_a  output  DATA_W  to kernel init_a
k_init_b  output  DATA_W  to kernel init_b
k_w_enable  input  1  from kernel w_enable (done, level)
k_result  input  DATA_W  from kernel result
resp_valid  output  1  response valid
resp_ready  input  1  consumer accepts response
resp_data  output  DATA_W  captured kernel result
resp_cycles  output  CNT_W  cycles spent in WAIT
resp_timeout  output  1  call aborted by timeout

Behaviour:
- One clock domain. rst is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=0 during reset, k_r_enable=1, k_control_arr=0, k_init_*=0, resp_valid=0, resp_data=0, resp_cycles=0, resp_timeout=0.
- Reset asserted mid-call forces IDLE immediately; no response is produced for the aborted call.
- Kernel parking rule: k_r_enable is 1 in every state except WAIT, so the kernel is held in its load state while idle.
- k_init_* are driven from the argument registers at all times.
- State IDLE:
  - req_ready=1, k_r_enable=1.
  - On req_valid&req_ready, latch req_n/a/b into the argument registers and go to LOAD.
- State LOAD:
  - Exactly 1 cycle. k_r_enable=1 with the new arguments present, so the kernel samples them on this edge.
  - Clear the counter to 0, then go to WAIT.
- State WAIT:
  - k_r_enable=0 and req_ready=0. The counter increments every WAIT cycle and saturates at all-ones.
  - k_w_enable is guaranteed 0 on WAIT entry, because the kernel cleared it during LOAD. No masking is required, but k_w_enable is sampled only in WAIT.
  - On k_w_enable=1: capture k_result into resp_data, set resp_cycles to the counter value including the current cycle, set resp_timeout=0, and go to RESP.
  - Example: k_w_enable high in the first WAIT cycle gives resp_cycles=1.
- State RESP:
  - resp_valid=1. resp_data, resp_cycles and resp_timeout are held stable until the handshake.
  - k_r_enable=1 (kernel re-parked; its w_enable drops to 0).
  - On resp_ready=1, go to IDLE. resp_valid deasserts the next cycle; resp_* hold their values until the next capture.
- Back-to-back calls: a new request cannot be accepted in RESP. Minimum request-to-request spacing is IDLE+LOAD+WAIT(≥1)+RESP = 4 cycles.
- Counter saturation: if the kernel takes at least 2^CNT_W−1 cycles, resp_cycles reads all-ones. This does not count as a timeout.
- resp_ready may be held high permanently; RESP then lasts exactly 1 cycle.

Optional Feature:
- Macro: CALL_TIMEOUT_EN.
- Defined:
  - In WAIT, if the counter reaches TIMEOUT_CYCLES without k_w_enable, go to RESP with resp_data=0, resp_cycles=TIMEOUT_CYCLES and resp_timeout=1.
  - The kernel is re-parked by k_r_enable=1 in RESP.
  - If k_w_enable=1 arrives in the same cycle the limit is reached, completion wins and resp_timeout=0.
- Undefined: WAIT waits indefinitely, resp_timeout is tied to 0, and TIMEOUT_CYCLES is unused.

Test Plan:
- Single call, behavioural kernel returning n+a+b after 5 cycles; req n=10 a=0 b=1 → k_init_* =10/0/1 during LOAD, k_r_enable low for exactly 5 cycles, resp_data=11, resp_cycles=5, resp_timeout=0.
- Back-to-back: two requests queued with resp_ready=1 → second req_ready pulse occurs exactly 1 cycle after the first resp_valid; both responses correct and in order.
- Backpressure: resp_ready=0 for 7 cycles after resp_valid → resp_* stable, req_ready=0 throughout, k_r_enable=1; accepted on the 8th cycle, then IDLE.
- Reset mid-WAIT: assert rst in the 3rd WAIT cycle → outputs take their reset values asynchronously (before the next clock edge), with k_r_enable=1; no resp_valid; the next call after release completes normally.
- Kernel done in 1 cycle → resp_cycles=1; k_w_enable already high from the previous call is ignored because the LOAD cycle clears it.
- With CALL_TIMEOUT_EN and TIMEOUT_CYCLES=8, kernel never completes → resp_valid after 8 WAIT cycles with resp_timeout=1, resp_data=0, resp_cycles=8; same test with completion in cycle 8 → resp_timeout=0.
